// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared timing defaults and helpers for the key debouncer.
package key_debounce_pkg;
    localparam int DEF_DEB_CYCLES    = 240000;
    localparam int DEF_LONG_CYCLES   = 12000000;
    localparam int DEF_REPEAT_CYCLES = 2400000;

    function automatic int cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic logic pol_norm(input logic pin, input logic active_low);
        return pin ^ active_low;
    endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel - synchroniser, stability filter and
// press/release/click/long/repeat pulse generation.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_click,
    output logic key_long,
    output logic key_repeat
);
    localparam int DW = cnt_w(DEB_CYCLES);
    localparam int LW = cnt_w(LONG_CYCLES);
    localparam int RW = cnt_w(REPEAT_CYCLES);
    localparam logic IDLE = ACTIVE_LOW != 0;

    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    logic [LW-1:0] hold;
    logic [RW-1:0] rcnt;
    logic          long_done;
    logic          s, mism, accept, press_ev, rel_ev, held, long_hit, rep_hit;

    // A release landing on the long/repeat target cycle suppresses that pulse.
    always_comb begin
        s        = pol_norm(sync[1], IDLE);
        mism     = s != key_state;
        accept   = mism && cnt == DW'(DEB_CYCLES - 1);
        press_ev = accept && !key_state;
        rel_ev   = accept && key_state;
        held     = key_state && !rel_ev;
        long_hit = held && !long_done && hold == LW'(LONG_CYCLES - 1);
        rep_hit  = held && long_done && rcnt == RW'(REPEAT_CYCLES - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync        <= {2{IDLE}};
            cnt         <= '0;
            hold        <= '0;
            rcnt        <= '0;
            long_done   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_click   <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync <= {sync[0], key};
            if (!mism) begin
                cnt <= '0;
            end else if (accept) begin
                key_state <= s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (press_ev)
                hold <= '0;
            else if (held && hold != LW'(LONG_CYCLES))
                hold <= hold + 1'b1;
            if (long_hit || !held)
                rcnt <= '0;
            else if (long_done)
                rcnt <= rep_hit ? '0 : rcnt + 1'b1;
            if (rel_ev)
                long_done <= 1'b0;
            else if (long_hit)
                long_done <= 1'b1;
            key_press   <= press_ev;
            key_release <= rel_ev;
            key_click   <= rel_ev && !long_done;
            key_long    <= long_hit;
            key_repeat  <= (REPEAT_EN != 0) && rep_hit;
        end
    end
endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N independent debounced key channels with event pulses.
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int N             = 4,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_state,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_click,
    output logic [N-1:0] key_long,
    output logic [N-1:0] key_repeat
);
    for (genvar i = 0; i < N; i++) begin : g_chan
        key_debounce_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key        (key[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_click  (key_click[i]),
            .key_long   (key_long[i]),
            .key_repeat (key_repeat[i])
        );
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed table, hand sequences and randomized
// stimulus checked against a timestamp-based reference model.
module tb_key_debounce_multi;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] key_hi = 2'b00;
    logic [1:0] st, pr, rl, ck, lg, rp;
    logic [1:0] st_h, pr_h, rl_h, ck_h, lg_h, rp_h;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_debounce_multi #(.N(2), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
                         .REPEAT_EN(1), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .key(key), .key_state(st), .key_press(pr),
        .key_release(rl), .key_click(ck), .key_long(lg), .key_repeat(rp));

    key_debounce_multi #(.N(2), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
                         .REPEAT_EN(1), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .key(key_hi), .key_state(st_h), .key_press(pr_h),
        .key_release(rl_h), .key_click(ck_h), .key_long(lg_h), .key_repeat(rp_h));

    // Reference model: pressed level is accepted once the synchronised pin has
    // disagreed with it for DEB consecutive samples; events from timestamps.
    logic [DEB+1:0] hist[2];
    logic [1:0] m_st, m_pr, m_rl, m_ck, m_lg, m_rp, long_f;
    int press_e[2], long_e[2];
    int e = 0;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c] = '0;
            press_e[c] = 0;
            long_e[c] = 0;
        end
        {m_st, m_pr, m_rl, m_ck, m_lg, m_rp, long_f} = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            e++;
            {m_pr, m_rl, m_ck, m_lg, m_rp} = '0;
            for (int c = 0; c < 2; c++) begin
                hist[c] = {hist[c][DEB:0], ~key[c]};
                if (hist[c][DEB+1:2] == {DEB{~m_st[c]}}) begin
                    m_st[c] = ~m_st[c];
                    if (m_st[c]) begin
                        m_pr[c] = 1'b1;
                        press_e[c] = e;
                    end else begin
                        m_rl[c] = 1'b1;
                        m_ck[c] = ~long_f[c];
                        long_f[c] = 1'b0;
                    end
                end else if (m_st[c]) begin
                    if (!long_f[c] && e - press_e[c] == LONG) begin
                        m_lg[c] = 1'b1;
                        long_f[c] = 1'b1;
                        long_e[c] = e;
                    end else if (long_f[c] && (e - long_e[c]) % REP == 0) begin
                        m_rp[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st/pr/rl/ck/lg/rp=%b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_out();
        return {st, pr, rl, ck, lg, rp};
    endfunction

    function automatic logic [11:0] hi_out();
        return {st_h, pr_h, rl_h, ck_h, lg_h, rp_h};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", dut_out(), {m_st, m_pr, m_rl, m_ck, m_lg, m_rp});
    endtask

    typedef struct {
        logic [1:0] key;
        int         cyc;
        logic [1:0] st, pr, rl, ck, lg, rp;
    } vec_t;

    vec_t tbl[$];
    int rem[2];

    initial begin
        tbl.push_back('{2'b10, 5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 18, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back('{2'b10, 7,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back('{2'b10, 7,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back('{2'b11, 5,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        for (int i = 0; i < 3; i++) begin
            tbl.push_back('{2'b10, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
            tbl.push_back('{2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        end
        tbl.push_back('{2'b11, 6,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 9,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 5,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10, 13, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 5,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 6,  2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 6,  2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00});
        tbl.push_back('{2'b11, 1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", dut_out(), 12'h000);
        chk("reset_hi", hi_out(), 12'h000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            key = tbl[i].key;
            repeat (tbl[i].cyc) step();
            chk($sformatf("tbl%0d", i), dut_out(),
                {tbl[i].st, tbl[i].pr, tbl[i].rl, tbl[i].ck, tbl[i].lg, tbl[i].rp});
        end

        key = 2'b10;
        repeat (6) step();
        chk("rst_pre_press", dut_out(), {2'b01, 2'b01, 8'h00});
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("rst_async", dut_out(), 12'h000);
        step();
        step();
        chk("rst_no_release", dut_out(), 12'h000);
        rst = 1'b0;
        repeat (5) step();
        chk("rst_wait", dut_out(), 12'h000);
        step();
        chk("rst_repress", dut_out(), {2'b01, 2'b01, 8'h00});
        key = 2'b11;
        repeat (8) step();

        key_hi = 2'b11;
        repeat (5) step();
        chk("hi_wait", hi_out(), 12'h000);
        step();
        chk("hi_press", hi_out(), {2'b11, 2'b11, 8'h00});
        step();
        chk("hi_hold", hi_out(), {2'b11, 10'h000});
        key_hi = 2'b00;
        repeat (5) step();
        step();
        chk("hi_release", hi_out(), {4'h0, 2'b11, 2'b11, 4'h0});
        step();
        chk("hi_idle", hi_out(), 12'h000);

        rem[0] = 0;
        rem[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    key[c] = 1'($urandom_range(0, 1));
                    rem[c] = $urandom_range(0, 1) != 0 ? $urandom_range(1, 5) : $urandom_range(6, 60);
                end
                rem[c]--;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                step();
                step();
                rst = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
